// File: rtl/lfsr_param_gen.sv
// Parametrised LFSR with Fibonacci/Galois structure, runtime seed/tap load,
// all-zero lockup recovery and hardware period measurement.
module lfsr_param_gen #(
    parameter int                WIDTH    = 16,
    parameter logic [WIDTH-1:0]  SEED_RST = 16'hACE1,
    parameter logic [WIDTH-1:0]  TAPS_RST = 16'hB400,
    parameter logic              MODE_RST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             taps_we,
    input  logic [WIDTH-1:0] taps_in,
    input  logic             mode_in,
    input  logic             step,
    output logic [WIDTH-1:0] state_out,
    output logic             bit_out,
    output logic             lockup,
    output logic             period_done,
    output logic [WIDTH-1:0] period_len
);

    logic [WIDTH-1:0] state_r;
    logic [WIDTH-1:0] taps_r;
    logic             mode_r;
    logic [WIDTH-1:0] ref_seed_r;
    logic [WIDTH-1:0] step_cnt_r;
    logic             lockup_r;
    logic             period_done_r;
    logic [WIDTH-1:0] period_len_r;

    logic [WIDTH-1:0] galois_next_s;
    logic [WIDTH-1:0] fib_next_s;
    logic [WIDTH-1:0] shift_next_s;
    logic [WIDTH-1:0] cnt_inc_s;
    logic             state_zero_s;
    logic             period_hit_s;

    // Feedback bit of the Fibonacci structure: parity of the tapped bits.
    function automatic logic fib_feedback(input logic [WIDTH-1:0] st, input logic [WIDTH-1:0] tp);
        return ^(st & tp);
    endfunction

    // Successor state for both structures, and period bookkeeping terms.
    always_comb begin
        galois_next_s = state_r >> 1;
        if (state_r[0]) begin
            galois_next_s = (state_r >> 1) ^ taps_r;
        end else begin
            galois_next_s = state_r >> 1;
        end
        fib_next_s = {fib_feedback(state_r, taps_r), state_r[WIDTH-1:1]};
        if (mode_r) begin
            shift_next_s = galois_next_s;
        end else begin
            shift_next_s = fib_next_s;
        end
        cnt_inc_s    = step_cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
        state_zero_s = (state_r == {WIDTH{1'b0}});
        period_hit_s = (shift_next_s == ref_seed_r);
    end

    // Tap mask and structure select; a write applies from the following step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps_r <= TAPS_RST;
            mode_r <= MODE_RST;
        end else if (ena && taps_we) begin
            taps_r <= taps_in;
            mode_r <= mode_in;
        end else begin
            taps_r <= taps_r;
            mode_r <= mode_r;
        end
    end

    // LFSR state, lockup recovery and period measurement; load wins over step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= SEED_RST;
            ref_seed_r    <= SEED_RST;
            step_cnt_r    <= {WIDTH{1'b0}};
            lockup_r      <= 1'b0;
            period_done_r <= 1'b0;
            period_len_r  <= {WIDTH{1'b0}};
        end else if (!ena) begin
            period_done_r <= 1'b0;
        end else begin
            period_done_r <= 1'b0;
            if (load) begin
                state_r    <= seed_in;
                ref_seed_r <= seed_in;
                step_cnt_r <= {WIDTH{1'b0}};
                lockup_r   <= 1'b0;
            end else if (step) begin
                if (state_zero_s) begin
                    // A zero state would shift forever; restart from the reset seed.
                    state_r    <= SEED_RST;
                    ref_seed_r <= SEED_RST;
                    step_cnt_r <= {WIDTH{1'b0}};
                    lockup_r   <= 1'b1;
                end else begin
                    state_r <= shift_next_s;
                    if (period_hit_s) begin
                        period_done_r <= 1'b1;
                        period_len_r  <= cnt_inc_s;
                        step_cnt_r    <= {WIDTH{1'b0}};
                    end else begin
                        step_cnt_r    <= cnt_inc_s;
                    end
                end
            end
        end
    end

    assign state_out   = state_r;
    assign bit_out     = state_r[0];
    assign lockup      = lockup_r;
    assign period_done = period_done_r;
    assign period_len  = period_len_r;

endmodule

// File: tb/tb_lfsr_param_gen.sv
// Self-checking bench for lfsr_param_gen: directed scenarios plus randomized
// traffic against a behavioural model, on a 16-bit and a 4-bit instance.
module tb_lfsr_param_gen;

    typedef struct packed {
        logic [31:0] state;
        logic [31:0] taps;
        logic [31:0] ref_seed;
        logic [31:0] cnt;
        logic [31:0] plen;
        logic        mode;
        logic        lock;
        logic        pdone;
    } model_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        ena, load, taps_we, mode_in, step;
    logic [15:0] seed_in, taps_in;
    logic [15:0] state_out, period_len;
    logic        bit_out, lockup, period_done;

    logic        ena4, load4, taps_we4, mode_in4, step4;
    logic [3:0]  seed_in4, taps_in4;
    logic [3:0]  state_out4, period_len4;
    logic        bit_out4, lockup4, period_done4;

    model_t m16, m4;
    int     checks = 0;
    int     passes = 0;

    always #5 clk = ~clk;

    lfsr_param_gen dut16 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .load(load), .seed_in(seed_in),
        .taps_we(taps_we), .taps_in(taps_in), .mode_in(mode_in), .step(step),
        .state_out(state_out), .bit_out(bit_out), .lockup(lockup),
        .period_done(period_done), .period_len(period_len)
    );

    lfsr_param_gen #(.WIDTH(4), .SEED_RST(4'h1), .TAPS_RST(4'hC), .MODE_RST(1'b1)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena4), .load(load4), .seed_in(seed_in4),
        .taps_we(taps_we4), .taps_in(taps_in4), .mode_in(mode_in4), .step(step4),
        .state_out(state_out4), .bit_out(bit_out4), .lockup(lockup4),
        .period_done(period_done4), .period_len(period_len4)
    );

    function automatic model_t model_reset(input logic [31:0] seed, input logic [31:0] taps, input logic mode);
        model_t r;
        r.state = seed; r.taps = taps; r.mode = mode; r.ref_seed = seed;
        r.cnt = 32'd0; r.plen = 32'd0; r.lock = 1'b0; r.pdone = 1'b0;
        return r;
    endfunction

    // Behavioural model: one clock of the generator described by its rules.
    function automatic model_t model_next(input model_t m, input int w, input logic [31:0] seed_rst,
                                          input bit en, input bit ld, input logic [31:0] sd,
                                          input bit twe, input logic [31:0] tin, input bit min, input bit st);
        model_t r;
        logic [31:0] mask, nxt, cnt;
        int fb;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        r = m;
        r.pdone = 1'b0;
        if (!en) return r;
        if (twe) begin
            r.taps = tin & mask;
            r.mode = min;
        end
        if (ld) begin
            r.state = sd & mask; r.ref_seed = sd & mask; r.cnt = 32'd0; r.lock = 1'b0;
        end else if (st) begin
            if (m.state == 32'd0) begin
                r.state = seed_rst; r.ref_seed = seed_rst; r.cnt = 32'd0; r.lock = 1'b1;
            end else begin
                if (m.mode) begin
                    nxt = (m.state / 2) ^ ((m.state % 2 == 1) ? m.taps : 32'd0);
                end else begin
                    fb  = $countones(m.state & m.taps) % 2;
                    nxt = (m.state / 2) + (fb * (32'd1 << (w - 1)));
                end
                cnt = (m.cnt + 32'd1) & mask;
                r.state = nxt;
                if (nxt == m.ref_seed) begin
                    r.pdone = 1'b1; r.plen = cnt; r.cnt = 32'd0;
                end else begin
                    r.cnt = cnt;
                end
            end
        end
        return r;
    endfunction

    task automatic cyc16(input bit en, input bit ld, input logic [15:0] sd, input bit twe,
                         input logic [15:0] tin, input bit min, input bit st);
        ena = en; load = ld; seed_in = sd; taps_we = twe; taps_in = tin; mode_in = min; step = st;
        @(posedge clk);
        m16 = model_next(m16, 16, 32'hACE1, en, ld, {16'h0, sd}, twe, {16'h0, tin}, min, st);
        #1;
    endtask

    task automatic cyc4(input bit st);
        ena4 = 1'b1; load4 = 1'b0; seed_in4 = 4'h0; taps_we4 = 1'b0; taps_in4 = 4'h0; mode_in4 = 1'b0; step4 = st;
        @(posedge clk);
        m4 = model_next(m4, 4, 32'h1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, st);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ena = 1'b0; load = 1'b0; seed_in = 16'h0; taps_we = 1'b0; taps_in = 16'h0; mode_in = 1'b0; step = 1'b0;
        ena4 = 1'b0; load4 = 1'b0; seed_in4 = 4'h0; taps_we4 = 1'b0; taps_in4 = 4'h0; mode_in4 = 1'b0; step4 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m16 = model_reset(32'hACE1, 32'hB400, 1'b1);
        m4  = model_reset(32'h1, 32'hC, 1'b1);
        checks++;
        if ({state_out, bit_out, lockup, period_done, period_len} !== {16'hACE1, 1'b1, 1'b0, 1'b0, 16'h0000})
            $display("FAIL reset16: got state=%h bit=%b lock=%b pd=%b plen=%h, expected ACE1/1/0/0/0000",
                     state_out, bit_out, lockup, period_done, period_len);
        else passes++;
        checks++;
        if ({state_out4, lockup4, period_done4, period_len4} !== {4'h1, 1'b0, 1'b0, 4'h0})
            $display("FAIL reset4: got state=%h lock=%b pd=%b plen=%h, expected 1/0/0/0",
                     state_out4, lockup4, period_done4, period_len4);
        else passes++;
    endtask

    task automatic test_galois_defaults;
        cyc16(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        checks++;
        if ({state_out, bit_out} !== {16'hE270, 1'b0})
            $display("FAIL galois_step1: got %h/%b expected E270/0", state_out, bit_out);
        else passes++;
        cyc16(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        checks++;
        if (state_out !== 16'h7138)
            $display("FAIL galois_step2: got %h expected 7138", state_out);
        else passes++;
    endtask

    task automatic test_fib_load;
        cyc16(1'b1, 1'b1, 16'hACE1, 1'b1, 16'h002D, 1'b0, 1'b0);
        checks++;
        if (state_out !== 16'hACE1)
            $display("FAIL fib_load: got %h expected ACE1", state_out);
        else passes++;
        cyc16(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        checks++;
        if (state_out !== 16'h5670)
            $display("FAIL fib_step: got %h expected 5670", state_out);
        else passes++;
    endtask

    task automatic test_taps_with_step;
        // Fibonacci taps 002D from 5670: tapped bits give feedback 1 -> AB38.
        cyc16(1'b1, 1'b0, 16'h0, 1'b1, 16'hB400, 1'b1, 1'b1);
        checks++;
        if (state_out !== 16'hAB38)
            $display("FAIL taps_old_used: got %h expected AB38", state_out);
        else passes++;
        cyc16(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        checks++;
        if (state_out !== 16'h559C)
            $display("FAIL taps_new_used: got %h expected 559C", state_out);
        else passes++;
    endtask

    task automatic test_load_step_and_ena;
        cyc16(1'b1, 1'b1, 16'h1234, 1'b0, 16'h0, 1'b0, 1'b1);
        checks++;
        if (state_out !== 16'h1234)
            $display("FAIL load_beats_step: got %h expected 1234", state_out);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            cyc16(1'b0, (i == 1), 16'hFFFF, 1'b1, 16'h0001, 1'b0, 1'b1);
            checks++;
            if ({state_out, period_done} !== {16'h1234, 1'b0})
                $display("FAIL ena_hold: got %h/%b expected 1234/0", state_out, period_done);
            else passes++;
        end
        // Taps stayed B400 Galois while disabled: 1234 even -> 091A.
        cyc16(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        checks++;
        if (state_out !== 16'h091A)
            $display("FAIL ena_taps_ignored: got %h expected 091A", state_out);
        else passes++;
    endtask

    task automatic test_period_rotate;
        // Fibonacci with only bit 0 tapped is a rotate: period 16.
        cyc16(1'b1, 1'b1, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            cyc16(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
            checks++;
            if (period_done !== (i == 16))
                $display("FAIL rot_pulse: step %0d got %b expected %b", i, period_done, (i == 16));
            else passes++;
        end
        checks++;
        if ({state_out, period_len} !== {16'h0001, 16'd16})
            $display("FAIL rot_len: got state=%h len=%0d expected 0001/16", state_out, period_len);
        else passes++;
        cyc16(1'b1, 1'b1, 16'h0003, 1'b0, 16'h0, 1'b0, 1'b0);
        checks++;
        if ({period_len, period_done} !== {16'd16, 1'b0})
            $display("FAIL len_held_on_load: got %0d/%b expected 16/0", period_len, period_done);
        else passes++;
    endtask

    task automatic test_lockup;
        cyc16(1'b1, 1'b1, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b0);
        cyc16(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        checks++;
        if ({state_out, lockup, period_done} !== {16'hACE1, 1'b1, 1'b0})
            $display("FAIL lockup_recover: got %h/%b/%b expected ACE1/1/0", state_out, lockup, period_done);
        else passes++;
        cyc16(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        checks++;
        if (lockup !== 1'b1)
            $display("FAIL lockup_sticky: got %b expected 1", lockup);
        else passes++;
        cyc16(1'b1, 1'b1, 16'h00FF, 1'b0, 16'h0, 1'b0, 1'b0);
        checks++;
        if ({state_out, lockup} !== {16'h00FF, 1'b0})
            $display("FAIL lockup_clear: got %h/%b expected 00FF/0", state_out, lockup);
        else passes++;
    endtask

    task automatic test_period_w4;
        int pulses = 0;
        int last = 0;
        for (int i = 1; i <= 45; i++) begin
            cyc4(1'b1);
            checks++;
            if (state_out4 === 4'h0 || {state_out4, period_done4, period_len4} !==
                {m4.state[3:0], m4.pdone, m4.plen[3:0]})
                $display("FAIL w4_seq: step %0d got %h/%b/%0d expected %h/%b/%0d", i, state_out4,
                         period_done4, period_len4, m4.state[3:0], m4.pdone, m4.plen[3:0]);
            else passes++;
            if (period_done4 === 1'b1) begin
                pulses++;
                checks++;
                if ((i - last) != 15 || period_len4 !== 4'd15)
                    $display("FAIL w4_period: interval %0d len %0d expected 15/15", i - last, period_len4);
                else passes++;
                last = i;
            end
        end
        ena4 = 1'b0; step4 = 1'b0;
        checks++;
        if (pulses != 3)
            $display("FAIL w4_pulse_count: got %0d expected 3", pulses);
        else passes++;
    endtask

    task automatic test_random;
        bit          en, ld, twe, min, st;
        logic [15:0] sd, tin;
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 7) != 0);
            ld  = ($urandom_range(0, 15) == 0);
            sd  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            twe = ($urandom_range(0, 15) == 0);
            tin = ($urandom_range(0, 1) == 0) ? 16'h0001 : 16'($urandom);
            min = 1'($urandom);
            st  = ($urandom_range(0, 3) != 0);
            cyc16(en, ld, sd, twe, tin, min, st);
            checks++;
            if ({state_out, bit_out, lockup, period_done, period_len} !==
                {m16.state[15:0], m16.state[0], m16.lock, m16.pdone, m16.plen[15:0]})
                $display("FAIL random: cycle %0d got %h/%b/%b/%b/%h expected %h/%b/%b/%b/%h", i,
                         state_out, bit_out, lockup, period_done, period_len, m16.state[15:0],
                         m16.state[0], m16.lock, m16.pdone, m16.plen[15:0]);
            else passes++;
        end
    endtask

    task automatic test_async_reset;
        cyc16(1'b1, 1'b1, 16'h0000, 1'b0, 16'h0, 1'b0, 1'b0);
        cyc16(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        ena = 1'b0; step = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state_out, lockup, period_done, period_len, state_out4} !== {16'hACE1, 1'b0, 1'b0, 16'h0000, 4'h1})
            $display("FAIL async_reset: got %h/%b/%b/%h/%h expected ACE1/0/0/0000/1",
                     state_out, lockup, period_done, period_len, state_out4);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        m16 = model_reset(32'hACE1, 32'hB400, 1'b1);
        cyc16(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        checks++;
        if (state_out !== 16'hE270)
            $display("FAIL post_reset_step: got %h expected E270", state_out);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_period_w4();
        test_galois_defaults();
        test_fib_load();
        test_taps_with_step();
        test_load_step_and_ena();
        test_period_rotate();
        test_lockup();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
